// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a big-endian byte stream into 32-bit words
// and writes them to instruction memory while holding the CPU in reset.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_e;

  localparam logic [31:0] MAXW = 32'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] asm_q, asm_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    case (state_q)
      // start is only honoured when no session is running
      IDLE, DONE: begin
        if (start) begin
          n_d     = (32'(word_count) > MAXW) ? MAXW[15:0] : word_count;
          idx_d   = '0;
          bcnt_d  = '0;
          state_d = (n_d == 16'd0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          case (bcnt_q)
            2'd0:    asm_d[31:24] = in_data;
            2'd1:    asm_d[23:16] = in_data;
            2'd2:    asm_d[15:8]  = in_data;
            default: asm_d[7:0]   = in_data;
          endcase
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        idx_d   = idx_q + 16'd1;
        state_d = (idx_d == n_q) ? DONE : COLLECT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == COLLECT);
    mem_we    = (state_q == WRITE);
    busy      = (state_q == COLLECT) || (state_q == WRITE);
    done      = (state_q == DONE);
    cpu_hold  = (state_q != DONE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == WRITE) begin
      mem_addr  = BASE_ADDR + {14'd0, idx_q, 2'b00};
      mem_wdata = asm_q;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued as words are driven,
// compared as mem_we pulses appear.
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;

  typedef struct { logic [31:0] a; logic [31:0] d; } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] word_count = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, mem_we, cpu_hold, busy, done;
  logic [31:0] mem_addr, mem_wdata;

  int   errors = 0;
  int   checks = 0;
  int   nwrites = 0;
  logic [31:0] last_addr = '0;
  exp_t sbq[$];

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard side
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_we) begin
        nwrites++;
        last_addr = mem_addr;
        chk("we_in_ready", {31'd0, in_ready}, 32'd0);
        chk("we_in_rst", {31'd0, rst}, 32'd0);
        if (sbq.size() == 0) begin
          chk("unexpected_we", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("addr", mem_addr, e.a);
          chk("wdata", mem_wdata, e.d);
        end
      end
    end
  end

  task automatic do_start(input logic [15:0] wc);
    @(posedge clk); #1;
    start = 1'b1; word_count = wc;
    @(posedge clk); #1;
    start = 1'b0; word_count = 16'hxxxx;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("byte_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'hxx;
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] w, input int gap);
    exp_t e;
    e.a = addr; e.d = w;
    sbq.push_back(e);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] t = w << (8 * k);
      send_byte(t[31:24], gap);
    end
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int w0;
    // reset values with clock running and rst held
    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_hold", {30'd0, busy, done}, 32'd0);

    // zero-length session: DONE right after the start edge
    w0 = nwrites;
    do_start(16'd0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_ready", {31'd0, in_ready}, 32'd0);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("zero_writes", 32'(nwrites - w0), 32'd0);

    // single word back-to-back
    do_start(16'd1);
    chk("one_busy", {31'd0, busy}, 32'd1);
    chk("one_hold", {31'd0, cpu_hold}, 32'd1);
    send_word(BASE, 32'h8C08_0000, 0);
    chk("one_we_next", {31'd0, mem_we}, 32'd1);
    @(posedge clk); #1;
    chk("one_done", {31'd0, done}, 32'd1);
    chk("one_cpu_hold", {31'd0, cpu_hold}, 32'd0);

    // three words, in_valid every other cycle
    do_start(16'd3);
    send_word(BASE + 32'h0, 32'hDEAD_BEEF, 1);
    send_word(BASE + 32'h4, 32'h0123_4567, 1);
    send_word(BASE + 32'h8, 32'hA5A5_5A5A, 1);
    wait_done();

    // start mid-session ignored, start in DONE honoured
    do_start(16'd2);
    send_word(BASE, 32'h1111_2222, 0);
    send_byte(8'h33, 0);
    do_start(16'd5);
    sbq.push_back('{a: BASE + 32'h4, d: 32'h3344_5566});
    send_byte(8'h44, 0);
    send_byte(8'h55, 2);
    send_byte(8'h66, 0);
    wait_done();
    do_start(16'd1);
    chk("restart_done", {31'd0, done}, 32'd0);
    chk("restart_hold", {31'd0, cpu_hold}, 32'd1);
    send_word(BASE, 32'hCAFE_F00D, 0);
    wait_done();

    // word_count clamp to MAX_WORDS
    w0 = nwrites;
    do_start(16'd1000);
    for (int i = 0; i < 256; i++) send_word(BASE + 32'(4 * i), $urandom, 0);
    wait_done();
    chk("clamp_writes", 32'(nwrites - w0), 32'd256);
    chk("clamp_last", last_addr, BASE + 32'h3FC);
    repeat (2) @(negedge clk);
    chk("clamp_stay_done", {31'd0, done}, 32'd1);

    // async reset mid-word discards the partial word
    do_start(16'd3);
    send_word(BASE, 32'h0BAD_F00D, 0);
    send_byte(8'hEE, 0);
    send_byte(8'hFF, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {30'd0, busy, done}, 32'd0);
    do_start(16'd1);
    send_word(BASE, 32'h7654_3210, 0);
    wait_done();

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written.
REQ-002 Parameter MAX_WORDS, default 256: upper limit on words loaded per session.
REQ-003 Port clk  input  1: single clock; all state changes on the rising edge.
REQ-004 Port rst  input  1: reset, asynchronous and active-high.
REQ-005 Port start  input  1: single-cycle request to begin a load session.
REQ-006 Port word_count  input  16: number of 32-bit words to load, sampled on accepted start.
REQ-007 Port in_valid  input  1: byte source has a byte on in_data.
REQ-008 Port in_data  input  8: program byte, most-significant byte of each word first.
REQ-009 Port in_ready  output  1: loader accepts in_data this cycle.
REQ-010 Port mem_we  output  1: instruction-memory word write strobe.
REQ-011 Port mem_addr  output  32: byte address of the word write, word-aligned.
REQ-012 Port mem_wdata  output  32: word to write.
REQ-013 Port cpu_hold  output  1: holds CPU (PC and fetch) in reset while high.
REQ-014 Port busy  output  1: load session in progress.
REQ-015 Port done  output  1: last session completed.

Function
REQ-016 FSM states SHALL be IDLE, COLLECT, WRITE, DONE.
REQ-017 IDLE: start=1 SHALL latch n = min(word_count, MAX_WORDS), clear word index and byte counter, and go to COLLECT, or to DONE if n==0.
REQ-018 Byte transfer SHALL occur only on a cycle with in_valid=1 and in_ready=1.
REQ-019 in_ready SHALL be 1 only in COLLECT.
REQ-020 Byte k (0..3) of a word SHALL be placed at bits [31-8k:24-8k] of the assembly register (big-endian).
REQ-021 When byte 3 transfers in cycle N, the FSM SHALL be in WRITE in cycle N+1, with mem_we=1, mem_wdata = assembled word, and mem_addr = BASE_ADDR + 4*index.
REQ-022 mem_we SHALL be high for exactly one cycle per word; mem_addr and mem_wdata are don't-care when mem_we=0.
REQ-023 Leaving WRITE: index increments; next state SHALL be DONE if the new index == n, else COLLECT.
REQ-024 Address arithmetic SHALL be 32-bit modulo 2^32; bits [1:0] of mem_addr SHALL always equal BASE_ADDR[1:0].
REQ-025 busy SHALL be 1 in COLLECT and WRITE, and 0 otherwise.
REQ-026 done SHALL be 1 only in DONE; cpu_hold SHALL be 0 only in DONE.
REQ-027 DONE: start=1 SHALL begin a new session exactly as in IDLE (REQ-017); otherwise the FSM SHALL remain in DONE.
REQ-028 start while busy SHALL be ignored; word_count changes while busy SHALL have no effect.
REQ-029 in_valid gaps of any length SHALL stall COLLECT without losing bytes already assembled.
REQ-030 Minimum session length SHALL be 5*n cycles from first byte acceptance to DONE.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, in_ready=0, mem_we=0, busy=0, done=0, cpu_hold=1, mem_addr=0, mem_wdata=0, index=0, byte counter=0, independent of clk.
REQ-032 Reset during COLLECT or WRITE SHALL discard the partial word; no mem_we pulse SHALL occur while rst=1 or in the first cycle after release.
REQ-033 After rst deassertion the FSM SHALL stay in IDLE until start.

Verification
REQ-034 Single word: start, word_count=1, bytes 8C,08,00,00 back-to-back -> one mem_we, mem_addr=BASE_ADDR, mem_wdata=8C080000; done=1 and cpu_hold=0 the next cycle.
REQ-035 Three words, BASE_ADDR=0x100, in_valid toggled every other cycle -> mem_we at addresses 0x100, 0x104, 0x108 with correct words; in_ready never high in WRITE.
REQ-036 word_count=0 -> DONE one cycle after start; no mem_we; in_ready stays 0.
REQ-037 word_count=1000 with MAX_WORDS=256 -> exactly 256 writes, last at BASE_ADDR+0x3FC, then DONE.
REQ-038 rst pulsed after 2 bytes of word 2 -> outputs reach reset values asynchronously; a new session rewrites from BASE_ADDR with a clean byte count.
REQ-039 start asserted mid-session and again in DONE -> first ignored; second starts a new session, done=0 and cpu_hold=1 the next cycle.
